xor_gate: RTL and testbench

XOR_GATE -- requirements
Module: xor_gate

---
 rtl/sat_counter.sv | 28 ++
 rtl/xor_gate.sv | 52 +++++
 tb/tb_xor_gate.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sat_counter.sv
// Saturating up-counter: advances by one on each cycle with inc high and
// sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic at_max;
  logic [CNT_W-1:0] count_next;

  assign at_max     = (count == CNT_MAX);
  assign count_next = count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR with a combinational output, a valid-qualified registered copy,
// its registered parity, and a saturating count of result changes.
module xor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             out_valid,
  output logic             parity_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] result;
  logic             toggle;

  assign result = A ^ B;
  assign Y      = result;

  // Compared against the stored Y_q, so the first sample after reset is
  // measured against zero.
  assign toggle = in_valid && (result != Y_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q       <= '0;
      parity_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y_q      <= result;
        parity_q <= ^result;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_toggle_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (toggle),
    .count(toggle_cnt)
  );

endmodule

// File: tb/tb_xor_gate.sv
// Scoreboard bench: two xor_gate instances (1-bit / 16-bit counter and
// 8-bit / 2-bit counter) driven in lockstep from directed and random stimulus.
module tb_xor_gate;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [7:0] a8 = '0, b8 = '0;

  logic [0:0]  y1, y_q1;
  logic        out_valid1, parity_q1;
  logic [15:0] toggle_cnt1;
  logic [7:0]  y8, y_q8;
  logic        out_valid8, parity_q8;
  logic [1:0]  toggle_cnt8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:0] y1;
    logic       p1;
    int         c1;
    logic [7:0] y8;
    logic       p8;
    int         c8;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state: last accepted result and toggle count per instance.
  logic [0:0] last1;
  logic [7:0] last8;
  int         cnt1, cnt8;

  always #5 clk = ~clk;

  xor_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(in_valid),
    .Y(y1), .Y_q(y_q1), .out_valid(out_valid1), .parity_q(parity_q1),
    .toggle_cnt(toggle_cnt1)
  );

  xor_gate #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(in_valid),
    .Y(y8), .Y_q(y_q8), .out_valid(out_valid8), .parity_q(parity_q8),
    .toggle_cnt(toggle_cnt8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last1 = '0;
    last8 = '0;
    cnt1  = 0;
    cnt8  = 0;
  endtask

  // Registered state must match the model of everything accepted so far.
  task automatic check_state(input string tag);
    check({tag, " Y_q1"}, y_q1, last1);
    check({tag, " parity1"}, parity_q1, $countones(last1) % 2);
    check({tag, " cnt1"}, toggle_cnt1, cnt1);
    check({tag, " Y_q8"}, y_q8, last8);
    check({tag, " parity8"}, parity_q8, $countones(last8) % 2);
    check({tag, " cnt8"}, toggle_cnt8, cnt8);
  endtask

  task automatic step(input logic [0:0] ia1, input logic [0:0] ib1,
                      input logic [7:0] ia8, input logic [7:0] ib8, input logic v);
    exp_t e;
    logic [0:0] r1;
    logic [7:0] r8;
    @(posedge clk);
    #2;
    if (!v) check_state("hold");
    a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8; in_valid = v;
    r1 = ia1 ^ ib1;
    r8 = ia8 ^ ib8;
    if (v) begin
      if (r1 != last1) cnt1 = (cnt1 < 65535) ? cnt1 + 1 : cnt1;
      if (r8 != last8) cnt8 = (cnt8 < 3) ? cnt8 + 1 : cnt8;
      last1 = r1;
      last8 = r8;
      e.y1 = r1; e.p1 = ($countones(r1) % 2) == 1; e.c1 = cnt1;
      e.y8 = r8; e.p8 = ($countones(r8) % 2) == 1; e.c8 = cnt8;
      sb.push_back(e);
    end
    #1;
    check("Y1 comb", y1, r1);
    check("Y8 comb", y8, r8);
    $display("step a1=%0b b1=%0b a8=%02h b8=%02h v=%0b y1=%0b y8=%02h", ia1, ib1, ia8, ib8, v, y1, y8);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " Y_q1"}, y_q1, 0);
    check({tag, " parity1"}, parity_q1, 0);
    check({tag, " out_valid1"}, out_valid1, 0);
    check({tag, " cnt1"}, toggle_cnt1, 0);
    check({tag, " Y_q8"}, y_q8, 0);
    check({tag, " parity8"}, parity_q8, 0);
    check({tag, " out_valid8"}, out_valid8, 0);
    check({tag, " cnt8"}, toggle_cnt8, 0);
  endtask

  // Asserted between edges: any sample driven before the next edge is dropped.
  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    check("rst_mid Y1", y1, a1 ^ b1);
    check("rst_mid Y8", y8, a8 ^ b8);
    sb.delete();
    model_reset();
    $display("reset asserted mid-cycle at %0t", $time);
    @(posedge clk);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: one line per output presented by the DUT.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_valid1", out_valid1, 1);
        check("out_valid8", out_valid8, 1);
        check("Y_q1", y_q1, mon_e.y1);
        check("parity_q1", parity_q1, mon_e.p1);
        check("toggle_cnt1", toggle_cnt1, mon_e.c1);
        check("Y_q8", y_q8, mon_e.y8);
        check("parity_q8", parity_q8, mon_e.p8);
        check("toggle_cnt8", toggle_cnt8, mon_e.c8);
        $display("out y_q1=%0b cnt1=%0d y_q8=%02h p8=%0b cnt8=%0d", y_q1, toggle_cnt1, y_q8, parity_q8, toggle_cnt8);
      end else begin
        check("idle out_valid1", out_valid1, 0);
        check("idle out_valid8", out_valid8, 0);
      end
    end
  end

  initial begin
    logic [3:0] ab;
    model_reset();
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Truth table, combinational only.
    for (int i = 0; i < 4; i++) begin
      ab = 4'(i);
      step(ab[1], ab[0], 8'($urandom), 8'($urandom), 1'b0);
    end

    // Same sequence registered; dut8 sees the A5/0F case first.
    for (int i = 0; i < 4; i++) begin
      ab = 4'(i);
      if (i == 0) step(ab[1], ab[0], 8'hA5, 8'h0F, 1'b1);
      else        step(ab[1], ab[0], 8'($urandom), 8'($urandom), 1'b1);
    end

    // Hold: inputs change, registered state must not.
    for (int i = 0; i < 3; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);

    step(1'b1, 1'b0, 8'h3C, 8'h81, 1'b1);
    reset_mid();

    // Alternating 1/0 results into the 2-bit counter.
    for (int i = 0; i < 5; i++)
      step(1'($urandom), 1'($urandom), (i % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 200; i++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
      if (i == 120) reset_mid();
    end

    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
